demux_bank_scheduler: RTL and testbench

//   Sequences the 1-to-16 data demux that feeds 16 on-chip buffer banks in the transpose-conv path.

---
 rtl/demux_bank_scheduler.sv | 153 +++++++++++++++
 tb/tb_demux_bank_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_bank_scheduler.sv
// Scheduler for the 1-to-16 demux feeding the transpose-conv buffer banks: spreads a
// cfg_num_banks x cfg_words_per_bank stream across banks. Define DEMUX_SCHED_BANK_MAJOR_EN for bank-major fill.
module demux_bank_scheduler #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4:0]            cfg_num_banks,
    input  logic [ADDR_WIDTH-1:0] cfg_words_per_bank,
    input  logic                  cfg_bank_major,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [3:0]            demux_sel,
    output logic [DATA_WIDTH-1:0] demux_data,
    output logic [15:0]           bank_we,
    output logic [ADDR_WIDTH-1:0] bank_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_BANKS = 16;
    localparam int unsigned SEL_W     = 4;
    localparam int unsigned CFG_N_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      bank_cnt_q, bank_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [SEL_W-1:0]      n_last_q, n_last_d;
    logic [ADDR_WIDTH-1:0] w_last_q, w_last_d;
    logic                  major_q, major_d;

    logic                  beat_c;
    logic                  bank_wrap_c;
    logic                  addr_wrap_c;
    logic                  last_beat_c;
    logic                  start_major_c;
    logic [CFG_N_W-1:0]    n_eff_c;

`ifdef DEMUX_SCHED_BANK_MAJOR_EN
    assign start_major_c = cfg_bank_major;
`else
    logic unused_bank_major;
    assign unused_bank_major = cfg_bank_major;
    assign start_major_c     = 1'b0;
`endif

    // State-derived status; s_ready decodes the state register only
    assign s_ready = (state_q == ST_RUN);
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

    // Next-state and counter sequencing
    always_comb begin
        state_d    = state_q;
        bank_cnt_d = bank_cnt_q;
        addr_cnt_d = addr_cnt_q;
        n_last_d   = n_last_q;
        w_last_d   = w_last_q;
        major_d    = major_q;

        beat_c      = s_valid && (state_q == ST_RUN);
        bank_wrap_c = (bank_cnt_q == n_last_q);
        addr_wrap_c = (addr_cnt_q == w_last_q);
        last_beat_c = beat_c && bank_wrap_c && addr_wrap_c;
        n_eff_c     = ((cfg_num_banks == '0) || (cfg_num_banks > CFG_N_W'(NUM_BANKS)))
                      ? CFG_N_W'(NUM_BANKS) : cfg_num_banks;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    n_last_d   = SEL_W'(n_eff_c - CFG_N_W'(1));
                    w_last_d   = cfg_words_per_bank - ADDR_WIDTH'(1);
                    major_d    = start_major_c;
                    bank_cnt_d = '0;
                    addr_cnt_d = '0;
                    state_d    = (cfg_words_per_bank == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_beat_c) begin
                    // Clear on the final beat so counters never pass N-1 / W-1
                    bank_cnt_d = '0;
                    addr_cnt_d = '0;
                    state_d    = ST_DONE;
                end else if (beat_c) begin
                    if (major_q) begin
                        if (addr_wrap_c) begin
                            addr_cnt_d = '0;
                            bank_cnt_d = bank_cnt_q + SEL_W'(1);
                        end else begin
                            addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                        end
                    end else begin
                        if (bank_wrap_c) begin
                            bank_cnt_d = '0;
                            addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
                        end else begin
                            bank_cnt_d = bank_cnt_q + SEL_W'(1);
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bank_cnt_q <= '0;
            addr_cnt_q <= '0;
            n_last_q   <= '0;
            w_last_q   <= '0;
            major_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_cnt_q <= bank_cnt_d;
            addr_cnt_q <= addr_cnt_d;
            n_last_q   <= n_last_d;
            w_last_q   <= w_last_d;
            major_q    <= major_d;
        end
    end

    // Demux/bank write port, one cycle behind the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            demux_sel  <= '0;
            demux_data <= '0;
            bank_we    <= '0;
            bank_addr  <= '0;
        end else begin
            bank_we <= beat_c ? (NUM_BANKS'(1) << bank_cnt_q) : '0;
            if (beat_c) begin
                demux_sel  <= bank_cnt_q;
                demux_data <= s_data;
                bank_addr  <= addr_cnt_q;
            end
        end
    end

endmodule

// File: tb/tb_demux_bank_scheduler.sv
// Randomized bench for demux_bank_scheduler against a beat-index reference model.
module tb_demux_bank_scheduler;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [4:0]    cfg_num_banks;
    logic [AW-1:0] cfg_words_per_bank;
    logic          cfg_bank_major;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [3:0]    demux_sel;
    logic [DW-1:0] demux_data;
    logic [15:0]   bank_we;
    logic [AW-1:0] bank_addr;
    logic          busy;
    logic          done;

    demux_bank_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .cfg_num_banks      (cfg_num_banks),
        .cfg_words_per_bank (cfg_words_per_bank),
        .cfg_bank_major     (cfg_bank_major),
        .s_valid            (s_valid),
        .s_data             (s_data),
        .s_ready            (s_ready),
        .demux_sel          (demux_sel),
        .demux_data         (demux_data),
        .bank_we            (bank_we),
        .bank_addr          (bank_addr),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a transfer is a count of beats k = 0..N*W-1 mapped to (bank, addr)
    bit            m_active;
    bit            m_done;
    int            m_k;
    int            m_n;
    int            m_w;
    bit            m_major;
    logic [15:0]   e_we;
    logic [3:0]    e_sel;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    function automatic void model_reset();
        m_active = 0; m_done = 0; m_k = 0; m_n = 0; m_w = 0; m_major = 0;
        e_we = '0; e_sel = '0; e_addr = '0; e_data = '0;
    endfunction

    function automatic void model_step();
        bit was_done;
        int bank;
        int addr;
        was_done = m_done;
        m_done   = 0;
        e_we     = '0;
        if (m_active) begin
            if (s_valid) begin
                if (m_major) begin
                    bank = m_k / m_w;
                    addr = m_k % m_w;
                end else begin
                    bank = m_k % m_n;
                    addr = m_k / m_n;
                end
                e_we   = 16'(1 << bank);
                e_sel  = 4'(bank);
                e_addr = AW'(addr);
                e_data = s_data;
                m_k++;
                if (m_k == m_n * m_w) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (!was_done && start) begin
            m_n = (cfg_num_banks == 0 || cfg_num_banks > 16) ? 16 : int'(cfg_num_banks);
            m_w = int'(cfg_words_per_bank);
`ifdef DEMUX_SCHED_BANK_MAJOR_EN
            m_major = cfg_bank_major;
`else
            m_major = 0;
`endif
            m_k = 0;
            if (m_w == 0) m_done = 1;
            else          m_active = 1;
        end
    endfunction

    task automatic compare_outputs(input string tag);
        check({tag, ":s_ready"},    32'(s_ready),    32'(m_active));
        check({tag, ":busy"},       32'(busy),       32'(m_active || m_done));
        check({tag, ":done"},       32'(done),       32'(m_done));
        check({tag, ":bank_we"},    32'(bank_we),    32'(e_we));
        check({tag, ":demux_sel"},  32'(demux_sel),  32'(e_sel));
        check({tag, ":bank_addr"},  32'(bank_addr),  32'(e_addr));
        check({tag, ":demux_data"}, 32'(demux_data), 32'(e_data));
    endtask

    task automatic drive_cycle(input string tag, input bit v, input bit st,
                               input int n, input int w, input bit maj);
        @(negedge clk);
        s_valid            = v;
        s_data             = DW'($urandom);
        start              = st;
        cfg_num_banks      = 5'(n);
        cfg_words_per_bank = AW'(w);
        cfg_bank_major     = maj;
        @(posedge clk);
        model_step();
        #1;
        compare_outputs(tag);
    endtask

    function automatic bit pick_valid(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    // One full transfer; cfg inputs are scrambled after the start cycle to prove they are latched
    task automatic run_xfer(input string tag, input int n, input int w, input bit maj,
                            input int mode, input bit spurious);
        int nn;
        int budget;
        int cyc;
        nn     = (n == 0 || n > 16) ? 16 : n;
        budget = 4 * nn * w + 20;
        cyc    = 0;
        drive_cycle(tag, pick_valid(mode, 1), 1'b1, n, w, maj);
        while ((m_active || m_done) && cyc < budget) begin
            drive_cycle(tag, pick_valid(mode, cyc), spurious && (cyc == 3),
                        $urandom_range(0, 31), $urandom_range(0, 7), 1'($urandom));
            cyc++;
        end
        drive_cycle({tag, ":idle"}, 1'($urandom), 1'b0, n, w, maj);
        check({tag, ":ended_idle"}, 32'(busy), 32'(0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
        cfg_num_banks = '0; cfg_words_per_bank = '0; cfg_bank_major = 1'b0;
        model_reset();

        // Reset held with s_valid toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = ~s_valid;
            start   = 1'b1;
            @(posedge clk);
            #1;
            compare_outputs("reset_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        drive_cycle("post_reset", 1'b1, 1'b0, 4, 3, 1'b0);

        run_xfer("n4w3",    4,  3, 1'b0, 0, 1'b0);
        run_xfer("n16w2",   16, 2, 1'b0, 1, 1'b0);
        run_xfer("w0",      5,  0, 1'b0, 0, 1'b0);
        run_xfer("n0w1",    0,  1, 1'b0, 0, 1'b0);
        run_xfer("n20w1",   20, 1, 1'b0, 2, 1'b0);
        run_xfer("spurious", 3, 2, 1'b0, 0, 1'b1);
        run_xfer("bmajor",  2,  3, 1'b1, 0, 1'b0);

        // Abort after five beats of N=4,W=4, then a clean restart
        drive_cycle("abort_start", 1'b0, 1'b1, 4, 4, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle("abort_beats", 1'b1, 1'b0, 4, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_outputs("abort_async");
        @(posedge clk);
        #1;
        compare_outputs("abort_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_xfer("restart", 4, 4, 1'b0, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_xfer("rand", $urandom_range(0, 20), $urandom_range(0, 6),
                     1'($urandom), 2, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
